serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor that computes `Diff = A - B` one bit per clock, LSB first, using a single half/full-subtractor cell and a registered borrow. It is the subtraction counterpart to the team's adder cells. It sits as a small arithmetic unit behind a start/done handshake, trading latency for area.

---
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B, one bit per clock, LSB first,
// behind a start/done handshake. Borrow is set iff A < B.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d, busy_q, busy_d, done_q, done_d, borrow_q, borrow_d;

  // Full-subtractor cell on the current LSBs
  logic a_bit, b_bit, d_bit, bw_next;
  logic [WIDTH-1:0] res_shift;

  assign a_bit   = sa_q[0];
  assign b_bit   = sb_q[0];
  assign d_bit   = a_bit ^ b_bit ^ bw_q;
  assign bw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);

  // Result fills from the MSB end so bit 0 lands at position 0 after WIDTH shifts
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_shift = d_bit;
    end else begin : g_wn
      assign res_shift = {d_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = RUN;
          sa_d    = A;
          sb_d    = B;
          cnt_d   = '0;
          bw_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_shift;
        bw_d  = bw_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = res_shift;
          borrow_d = bw_next;
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance and a 1-bit instance
// sharing clock and reset, with hand-computed expected results.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] A8, B8, Diff8;
  logic [0:0] A1, B1, Diff1;
  logic       busy8, done8, Borrow8, busy1, done1, Borrow1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .Diff(Diff8), .Borrow(Borrow8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
    .busy(busy1), .done(done1), .Diff(Diff1), .Borrow(Borrow1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single 8-bit operation with full cycle-by-cycle handshake checking
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input string tag);
    A8 = a; B8 = b; start8 = 1'b1;
    step();
    start8 = 1'b0;
    A8 = ~a; B8 = ~b;  // later operand changes must not matter
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, 32'(busy8), 32'd1);
      chk({tag, "_nodone"}, 32'(done8), 32'd0);
      step();
    end
    chk({tag, "_done"}, 32'(done8), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy8), 32'd1);
    chk({tag, "_diff"}, 32'(Diff8), 32'(ed));
    chk({tag, "_borrow"}, 32'(Borrow8), 32'(eb));
    step();
    chk({tag, "_idle"}, 32'(busy8), 32'd0);
    chk({tag, "_done_clr"}, 32'(done8), 32'd0);
    chk({tag, "_diff_hold"}, 32'(Diff8), 32'(ed));
  endtask

  task automatic op1(input logic a, input logic b, input logic ed, input logic eb,
                     input string tag);
    A1 = a; B1 = b; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk({tag, "_busy"}, 32'(busy1), 32'd1);
    chk({tag, "_nodone"}, 32'(done1), 32'd0);
    step();
    chk({tag, "_done"}, 32'(done1), 32'd1);
    chk({tag, "_diff"}, 32'(Diff1), 32'(ed));
    chk({tag, "_borrow"}, 32'(Borrow1), 32'(eb));
    step();
    chk({tag, "_idle"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    int ndone, first_cyc, second_cyc;
    logic [7:0] dseen;

    rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
    A8 = 8'h55; B8 = 8'h11; A1 = 1'b1; B1 = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(Diff8), 32'd0);
    chk("rst_borrow", 32'(Borrow8), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    start8 = 1'b0; start1 = 1'b0;
    rst = 1'b0;
    step();
    chk("rst_start_ignored", 32'(busy8), 32'd0);

    op8(8'h35, 8'h12, 8'h23, 1'b0, "basic");
    op8(8'h00, 8'h01, 8'hFF, 1'b1, "under");
    op8(8'hA5, 8'hA5, 8'h00, 1'b0, "equal");
    op8(8'h80, 8'hFF, 8'h81, 1'b1, "m80");

    // start pulsed in the 3rd RUN cycle must be dropped
    A8 = 8'h50; B8 = 8'h20; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    A8 = 8'h10; B8 = 8'h01; start8 = 1'b1;
    step();
    start8 = 1'b0;
    ndone = 0; dseen = 8'h00;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin ndone++; dseen = Diff8; end
      step();
    end
    chk("busyrej_ndone", 32'(ndone), 32'd1);
    chk("busyrej_diff", 32'(dseen), 32'h30);
    chk("busyrej_idle", 32'(busy8), 32'd0);

    // reset in the 4th RUN cycle aborts the operation
    A8 = 8'h7F; B8 = 8'h01; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_diff", 32'(Diff8), 32'd0);
    chk("midrst_borrow", 32'(Borrow8), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      step();
    end
    chk("midrst_nodone", 32'(ndone), 32'd0);
    op8(8'h03, 8'h05, 8'hFE, 1'b1, "after_rst");

    // held start: back-to-back, done pulses WIDTH+2 apart
    A8 = 8'h09; B8 = 8'h04; start8 = 1'b1;
    first_cyc = -1; second_cyc = -1;
    for (int i = 0; i < 40 && second_cyc < 0; i++) begin
      step();
      if (done8) begin
        if (first_cyc < 0) begin
          first_cyc = i;
          chk("b2b_diff1", 32'(Diff8), 32'h05);
          chk("b2b_borrow1", 32'(Borrow8), 32'd0);
          A8 = 8'h02;
        end else begin
          second_cyc = i;
          chk("b2b_diff2", 32'(Diff8), 32'hFE);
          chk("b2b_borrow2", 32'(Borrow8), 32'd1);
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    chk("b2b_got_both", 32'(second_cyc >= 0 && first_cyc >= 0), 32'd1);
    chk("b2b_spacing", 32'(second_cyc - first_cyc), 32'd10);
    for (int i = 0; i < 12; i++) step();
    chk("b2b_idle", 32'(busy8), 32'd0);

    op1(1'b0, 1'b0, 1'b0, 1'b0, "w1_00");
    op1(1'b0, 1'b1, 1'b1, 1'b1, "w1_01");
    op1(1'b1, 1'b0, 1'b1, 1'b0, "w1_10");
    op1(1'b1, 1'b1, 1'b0, 1'b0, "w1_11");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
